ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// - Shares one valid/ready/wstrb RAM port between two masters: M0 (CPU load/store) and M1 (accelerator DMA).
// - Sits between the masters and the single RAM port. Masters keep mem-style semantics (hold valid/addr/wdata/wstrb until ready).
// - FSM-based grant with round-robin or fixed priority, a per-transaction lock, and a slave-response timeout.
// PARAMETERS
// - PRIORITY_MODE   0   0 = round-robin between M0/M1; 1 = fixed priority, M0 wins
// - TIMEOUT_CYCLES  16  cycles in a grant state without s_ready before forced completion; 0 disables
// - CNT_W           8   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
// - clk          in   1   clock, all logic on rising edge
// - rst          in   1   synchronous reset, active-high
// - m0_valid     in   1   M0 request; held until m0_ready
// - m0_ready     out  1   M0 transfer complete (one-cycle pulse)
// - m0_addr      in   32  M0 byte address
// - m0_wdata     in   32  M0 write data
// - m0_wstrb     in   4   M0 byte enables; 0 = read
// - m0_rdata     out  32  M0 read data, valid when m0_ready
// - m1_valid     in   1   M1 request; same as M0
// - m1_ready     out  1   M1 transfer complete
// - m1_addr      in   32  M1 byte address
// - m1_wdata     in   32  M1 write data
// - m1_wstrb     in   4   M1 byte enables
// - m1_rdata     out  32  M1 read data
// - s_valid      out  1   request to RAM port
// - s_ready      in   1   RAM completion; may be combinational from s_valid
// - s_addr       out  32  muxed address
// - s_wdata      out  32  muxed write data
// - s_wstrb      out  4   muxed byte enables
// - s_rdata      in   32  RAM read data
// - grant        out  2   one-hot current owner {M1,M0}; 00 in IDLE
// - timeout_err  out  1   one-cycle pulse when a transfer is force-completed
// BEHAVIOUR
// - States: IDLE, GNT0, GNT1. State, grant, last_owner, timeout counter and timeout_err are registered.
// - The s_* and m*_ready/rdata outputs are combinational from the state.
// - Reset: state=IDLE, grant=00, last_owner=M1 (so M0 wins the first tie), counter=0, timeout_err=0.
// - In IDLE: s_valid=0, s_addr/s_wdata/s_wstrb=0, m0_ready=m1_ready=0, m*_rdata=0.
// - IDLE, request evaluation:
//   - If only one master is valid, go to its GNT state.
//   - If both are valid and PRIORITY_MODE=1, go to GNT0.
//   - If both are valid and PRIORITY_MODE=0, grant the master that is not last_owner.
//   - If neither is valid, stay in IDLE.
// - GNTx routing:
//   - s_valid = mx_valid; s_addr, s_wdata, s_wstrb = mx_*.
//   - mx_ready = s_valid & s_ready; mx_rdata = s_rdata.
//   - The non-granted master sees ready=0 and rdata=0.
// - GNTx completion (s_valid & s_ready):
//   - Set last_owner = x and clear the counter.
//   - If the other master's valid is high this cycle, go straight to its GNT state (no bubble).
//   - Otherwise go to IDLE.
//   - The completing master's valid is ignored at completion, so a stale valid is never re-granted.
// - GNTx with mx_valid dropped (protocol violation): go to IDLE next cycle, no ready issued.
// - Latency:
//   - From IDLE with a combinational-ready RAM: valid at cycle 0, ready at cycle 1.
//   - Alternating masters stream one transfer per cycle after the first.
// - Timeout (TIMEOUT_CYCLES>0): the counter increments each GNT cycle without s_ready.
//   - When counter == TIMEOUT_CYCLES-1 and s_ready=0: force mx_ready=1 with mx_rdata=0 that cycle.
//   - Drop s_valid that same cycle.
//   - Pulse timeout_err on the next cycle.
//   - Take the normal completion transition.
// - Reset mid-transfer: returns to IDLE immediately. No ready is issued to the in-flight master; it must re-request.
// - Writes reach RAM only through s_wstrb of the granted master. No write is ever issued in IDLE.
// TESTING
// - Single M0 write 0xDEADBEEF @0x00010010, wstrb=F, then read -> m0_ready at cycle 1 each; read returns 0xDEADBEEF; grant=01.
// - Both valid at cycle 0 after reset, round-robin: order is M0 then M1 back-to-back; m0_ready @1, m1_ready @2; then M0 again if still requesting.
// - PRIORITY_MODE=1, M0 and M1 continuously valid -> M0 owns every transfer; M1 only gets a grant when M0 valid drops.
// - Byte write wstrb=0100, wdata=0x00AB0000 from M1 over 0x11223344 -> M0 read returns 0x11AB3344.
// - s_ready stuck 0, TIMEOUT_CYCLES=16 -> m0_ready with rdata=0 on the 16th grant cycle; timeout_err pulse next cycle; M1 then served.
// - Assert rst during GNT1 -> next cycle grant=00, s_valid=0, no m1_ready pulse; M1 re-request completes normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single valid/ready/wstrb RAM port.
// M0 is the CPU load/store path, M1 the accelerator DMA. A grant is held
// for one whole transfer; a stuck slave is cut loose after TIMEOUT_CYCLES.
module ram_port_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    state_t              cur_state;
    logic                last_owner_q;   // 0 = M0, 1 = M1
    logic                last_owner_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [1:0]          grant_d;
    logic                tmo_fire;
    logic                xfer_done;

    logic                sel_m1;
    logic                own_valid;
    logic                other_valid;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic [STRB_W-1:0]   own_wstrb;
    logic                own_ready;
    logic [DATA_W-1:0]   own_rdata;

    // Reset forces IDLE behaviour in the same cycle, so an in-flight master never sees ready.
    assign cur_state = rst ? ST_IDLE : state_q;

    // Request payload of the master the current state grants.
    always_comb begin
        sel_m1      = (cur_state == ST_GNT1);
        own_valid   = sel_m1 ? m1_valid : m0_valid;
        other_valid = sel_m1 ? m0_valid : m1_valid;
        own_addr    = sel_m1 ? m1_addr  : m0_addr;
        own_wdata   = sel_m1 ? m1_wdata : m0_wdata;
        own_wstrb   = sel_m1 ? m1_wstrb : m0_wstrb;
    end

    // Next-state, slave-side routing and timeout detection.
    always_comb begin
        state_d      = cur_state;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        tmo_fire     = 1'b0;
        xfer_done    = 1'b0;
        own_ready    = 1'b0;
        own_rdata    = '0;
        s_valid      = 1'b0;
        s_addr       = '0;
        s_wdata      = '0;
        s_wstrb      = '0;

        case (cur_state)
            ST_IDLE: begin
                cnt_d = '0;
                if (m0_valid && m1_valid) begin
                    // Tie: fixed priority favours M0, round-robin favours the non-last owner.
                    if ((PRIORITY_MODE != 0) || last_owner_q) begin
                        state_d = ST_GNT0;
                    end else begin
                        state_d = ST_GNT1;
                    end
                end else if (m0_valid) begin
                    state_d = ST_GNT0;
                end else if (m1_valid) begin
                    state_d = ST_GNT1;
                end
            end

            ST_GNT0, ST_GNT1: begin
                tmo_fire  = TMO_EN && own_valid && !s_ready && (cnt_q == TMO_LAST);
                s_valid   = own_valid && !tmo_fire;
                s_addr    = own_addr;
                s_wdata   = own_wdata;
                s_wstrb   = own_wstrb;
                xfer_done = (s_valid && s_ready) || tmo_fire;
                own_ready = xfer_done;
                own_rdata = tmo_fire ? '0 : s_rdata;

                if (!own_valid) begin
                    // Master withdrew its request: abandon the grant without a ready.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (xfer_done) begin
                    // The completing master's valid is stale here, so only the other one can follow.
                    last_owner_d = sel_m1;
                    cnt_d        = '0;
                    if (other_valid) begin
                        state_d = sel_m1 ? ST_GNT0 : ST_GNT1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only the granted master sees ready/rdata; the other is held at zero.
    always_comb begin
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (cur_state == ST_GNT0) begin
            m0_ready = own_ready;
            m0_rdata = own_rdata;
        end else if (cur_state == ST_GNT1) begin
            m1_ready = own_ready;
            m1_rdata = own_rdata;
        end
    end

    // One-hot owner of the next cycle.
    always_comb begin
        case (state_d)
            ST_GNT0: grant_d = 2'b01;
            ST_GNT1: grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    // State, owner history, timeout counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant        <= 2'b00;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant        <= grant_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            timeout_err  <= tmo_fire;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Each instance has its own small RAM; a transfer-level reference model
// predicts every output each cycle and tracks the expected memory contents.
module tb_ram_port_arbiter;

    localparam int NI   = 2;
    localparam int TMO  = 16;
    localparam int NW   = 16;

    logic        clk = 1'b0;
    logic        rst       [NI];
    logic        m0_valid  [NI];
    logic        m0_ready  [NI];
    logic [31:0] m0_addr   [NI];
    logic [31:0] m0_wdata  [NI];
    logic [3:0]  m0_wstrb  [NI];
    logic [31:0] m0_rdata  [NI];
    logic        m1_valid  [NI];
    logic        m1_ready  [NI];
    logic [31:0] m1_addr   [NI];
    logic [31:0] m1_wdata  [NI];
    logic [3:0]  m1_wstrb  [NI];
    logic [31:0] m1_rdata  [NI];
    logic        s_valid   [NI];
    logic        s_ready   [NI];
    logic [31:0] s_addr    [NI];
    logic [31:0] s_wdata   [NI];
    logic [3:0]  s_wstrb   [NI];
    logic [31:0] s_rdata   [NI];
    logic [1:0]  grant     [NI];
    logic        timeout_err [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          own      [NI];   // 0 none, 1 M0, 2 M1
    bit          last1    [NI];   // last owner was M1
    int          wait_c   [NI];
    bit          terr_exp [NI];
    logic [31:0] ref_mem  [NI][NW];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] mem [NW];

        ram_port_arbiter #(
            .PRIORITY_MODE (g),
            .TIMEOUT_CYCLES(TMO),
            .CNT_W         (8)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .m0_valid   (m0_valid[g]),
            .m0_ready   (m0_ready[g]),
            .m0_addr    (m0_addr[g]),
            .m0_wdata   (m0_wdata[g]),
            .m0_wstrb   (m0_wstrb[g]),
            .m0_rdata   (m0_rdata[g]),
            .m1_valid   (m1_valid[g]),
            .m1_ready   (m1_ready[g]),
            .m1_addr    (m1_addr[g]),
            .m1_wdata   (m1_wdata[g]),
            .m1_wstrb   (m1_wstrb[g]),
            .m1_rdata   (m1_rdata[g]),
            .s_valid    (s_valid[g]),
            .s_ready    (s_ready[g]),
            .s_addr     (s_addr[g]),
            .s_wdata    (s_wdata[g]),
            .s_wstrb    (s_wstrb[g]),
            .s_rdata    (s_rdata[g]),
            .grant      (grant[g]),
            .timeout_err(timeout_err[g])
        );

        assign s_rdata[g] = mem[s_addr[g][5:2]];

        // RAM: preloaded on reset, byte-merged writes on accepted transfers.
        always @(posedge clk) begin
            if (rst[g]) begin
                for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
            end else if (s_valid[g] && s_ready[g]) begin
                mem[s_addr[g][5:2]] <= merge(mem[s_addr[g][5:2]], s_wdata[g], s_wstrb[g]);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict and compare all outputs of instance k for the current cycle, then advance the model.
    task automatic model_check(input int k, output bit rdy0, output bit rdy1);
        bit          v0, v1, sr, ov, ovo, fire, done, x1;
        logic [31:0] ea, ew, erd, got_own_rd;
        logic [3:0]  es;
        logic [1:0]  eg;
        string       p;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        p  = $sformatf("i%0d.", k);
        v0 = m0_valid[k];
        v1 = m1_valid[k];
        sr = s_ready[k];
        if (rst[k]) begin
            check_eq({p, "rst.s_valid"},  32'(s_valid[k]),  32'd0);
            check_eq({p, "rst.m0_ready"}, 32'(m0_ready[k]), 32'd0);
            check_eq({p, "rst.m1_ready"}, 32'(m1_ready[k]), 32'd0);
            own[k]      = 0;
            last1[k]    = 1'b1;
            wait_c[k]   = 0;
            terr_exp[k] = 1'b0;
            for (int i = 0; i < NW; i++) ref_mem[k][i] = init_word(i);
            return;
        end
        eg = (own[k] == 1) ? 2'b01 : (own[k] == 2) ? 2'b10 : 2'b00;
        check_eq({p, "grant"}, 32'(grant[k]), 32'(eg));
        check_eq({p, "timeout_err"}, 32'(timeout_err[k]), 32'(terr_exp[k]));
        if (own[k] == 0) begin
            check_eq({p, "idle.s_valid"},  32'(s_valid[k]),  32'd0);
            check_eq({p, "idle.s_addr"},   s_addr[k],        32'd0);
            check_eq({p, "idle.s_wstrb"},  32'(s_wstrb[k]),  32'd0);
            check_eq({p, "idle.m0_ready"}, 32'(m0_ready[k]), 32'd0);
            check_eq({p, "idle.m1_ready"}, 32'(m1_ready[k]), 32'd0);
            check_eq({p, "idle.m0_rdata"}, m0_rdata[k],      32'd0);
            check_eq({p, "idle.m1_rdata"}, m1_rdata[k],      32'd0);
            terr_exp[k] = 1'b0;
            wait_c[k]   = 0;
            if (v0 && v1)  own[k] = (k == 1 || last1[k]) ? 1 : 2;
            else if (v0)   own[k] = 1;
            else if (v1)   own[k] = 2;
        end else begin
            x1   = (own[k] == 2);
            ov   = x1 ? v1 : v0;
            ovo  = x1 ? v0 : v1;
            ea   = x1 ? m1_addr[k]  : m0_addr[k];
            ew   = x1 ? m1_wdata[k] : m0_wdata[k];
            es   = x1 ? m1_wstrb[k] : m0_wstrb[k];
            fire = ov && !sr && (wait_c[k] == TMO - 1);
            done = ov && (sr || fire);
            erd  = fire ? 32'd0 : s_rdata[k];
            check_eq({p, "gnt.s_valid"}, 32'(s_valid[k]), 32'(ov && !fire));
            check_eq({p, "gnt.s_addr"},  s_addr[k],  ea);
            check_eq({p, "gnt.s_wdata"}, s_wdata[k], ew);
            check_eq({p, "gnt.s_wstrb"}, 32'(s_wstrb[k]), 32'(es));
            got_own_rd = x1 ? m1_rdata[k] : m0_rdata[k];
            check_eq({p, "gnt.own_ready"}, 32'(x1 ? m1_ready[k] : m0_ready[k]), 32'(done));
            check_eq({p, "gnt.own_rdata"}, got_own_rd, erd);
            check_eq({p, "gnt.oth_ready"}, 32'(x1 ? m0_ready[k] : m1_ready[k]), 32'd0);
            check_eq({p, "gnt.oth_rdata"}, x1 ? m0_rdata[k] : m1_rdata[k], 32'd0);
            if (done && !fire) begin
                if (es == 4'h0) check_eq({p, "rd_data"}, got_own_rd, ref_mem[k][ea[5:2]]);
                else ref_mem[k][ea[5:2]] = merge(ref_mem[k][ea[5:2]], ew, es);
            end
            terr_exp[k] = fire;
            if (!ov) begin
                own[k]    = 0;
                wait_c[k] = 0;
            end else if (done) begin
                last1[k]  = x1;
                wait_c[k] = 0;
                own[k]    = ovo ? (x1 ? 1 : 2) : 0;
                if (x1) rdy1 = 1'b1; else rdy0 = 1'b1;
            end else begin
                wait_c[k]++;
            end
        end
    endtask

    task automatic cyc(input int k, output bit r0, output bit r1);
        @(negedge clk);
        model_check(k, r0, r1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int k, output bit r0, output bit r1);
        cyc(k, r0, r1);
        tick();
    endtask

    task automatic set_req(input int k, input int m, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0_valid[k] = 1'b1; m0_addr[k] = a; m0_wdata[k] = d; m0_wstrb[k] = s;
        end else begin
            m1_valid[k] = 1'b1; m1_addr[k] = a; m1_wdata[k] = d; m1_wstrb[k] = s;
        end
    endtask

    task automatic clr_req(input int k, input int m);
        if (m == 0) m0_valid[k] = 1'b0;
        else        m1_valid[k] = 1'b0;
    endtask

    task automatic do_reset(input int k);
        bit r0, r1;
        rst[k] = 1'b1;
        clr_req(k, 0);
        clr_req(k, 1);
        s_ready[k] = 1'b0;
        step(k, r0, r1);
        rst[k] = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h0001_0000 + 32'($urandom_range(0, NW - 1)) * 32'd4;
    endfunction

    task automatic run_random(input int k, input int ncyc);
        bit pend0, pend1, r0, r1;
        int stall;
        pend0 = 1'b0;
        pend1 = 1'b0;
        stall = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1'b1;
                set_req(k, 0, rnd_addr(), $urandom(),
                        ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0);
            end else if (pend0 && $urandom_range(0, 99) == 0) begin
                pend0 = 1'b0;
                clr_req(k, 0);
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1'b1;
                set_req(k, 1, rnd_addr(), $urandom(),
                        ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0);
            end else if (pend1 && $urandom_range(0, 99) == 0) begin
                pend1 = 1'b0;
                clr_req(k, 1);
            end
            if (stall > 0) begin
                stall--;
                s_ready[k] = 1'b0;
            end else begin
                if ($urandom_range(0, 59) == 0) stall = $urandom_range(10, 24);
                s_ready[k] = ($urandom_range(0, 3) != 0);
            end
            step(k, r0, r1);
            if (r0) begin pend0 = 1'b0; clr_req(k, 0); end
            if (r1) begin pend1 = 1'b0; clr_req(k, 1); end
        end
        clr_req(k, 0);
        clr_req(k, 1);
        s_ready[k] = 1'b1;
        for (int c = 0; c < 3; c++) step(k, r0, r1);
    endtask

    initial begin
        bit r0, r1;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            m0_valid[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0; m0_wstrb[k] = '0;
            m1_valid[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0; m1_wstrb[k] = '0;
            s_ready[k] = 1'b0;
            own[k] = 0; last1[k] = 1'b1; wait_c[k] = 0; terr_exp[k] = 1'b0;
        end
        tick();
        do_reset(1);
        do_reset(0);

        // Single M0 write then read back
        set_req(0, 0, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF);
        s_ready[0] = 1'b1;
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("wr.m0_ready", 32'(m0_ready[0]), 32'd1);
        check_eq("wr.grant", 32'(grant[0]), 32'h1);
        tick();
        set_req(0, 0, 32'h0001_0010, 32'h0, 4'h0);
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("rd.m0_ready", 32'(m0_ready[0]), 32'd1);
        check_eq("rd.m0_rdata", m0_rdata[0], 32'hDEAD_BEEF);
        check_eq("rd.grant", 32'(grant[0]), 32'h1);
        tick();
        clr_req(0, 0);
        step(0, r0, r1);

        // Round-robin: both valid after reset -> M0, M1, M0
        do_reset(0);
        s_ready[0] = 1'b1;
        set_req(0, 0, 32'h0001_0004, 32'h0, 4'h0);
        set_req(0, 1, 32'h0001_0008, 32'h1234_5678, 4'hF);
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("rr.c1.m0_ready", 32'(m0_ready[0]), 32'd1);
        check_eq("rr.c1.m1_ready", 32'(m1_ready[0]), 32'd0);
        tick();
        set_req(0, 0, 32'h0001_0008, 32'h0, 4'h0);
        cyc(0, r0, r1);
        check_eq("rr.c2.m1_ready", 32'(m1_ready[0]), 32'd1);
        check_eq("rr.c2.grant", 32'(grant[0]), 32'h2);
        tick();
        clr_req(0, 1);
        cyc(0, r0, r1);
        check_eq("rr.c3.m0_ready", 32'(m0_ready[0]), 32'd1);
        check_eq("rr.c3.m0_rdata", m0_rdata[0], 32'h1234_5678);
        tick();
        clr_req(0, 0);
        step(0, r0, r1);
        // Last owner M0: a fresh tie goes to M1
        set_req(0, 0, 32'h0001_000C, 32'h0, 4'h0);
        set_req(0, 1, 32'h0001_000C, 32'h0, 4'h0);
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("rr.tie.grant", 32'(grant[0]), 32'h2);
        tick();
        clr_req(0, 1);
        step(0, r0, r1);
        clr_req(0, 0);
        step(0, r0, r1);

        // Fixed priority: M0 wins the tie even right after owning the port
        s_ready[1] = 1'b1;
        set_req(1, 0, 32'h0001_0000, 32'h0, 4'h0);
        step(1, r0, r1);
        step(1, r0, r1);
        clr_req(1, 0);
        step(1, r0, r1);
        set_req(1, 0, 32'h0001_0004, 32'h0, 4'h0);
        set_req(1, 1, 32'h0001_0008, 32'h0, 4'h0);
        step(1, r0, r1);
        cyc(1, r0, r1);
        check_eq("fp.tie.grant", 32'(grant[1]), 32'h1);
        check_eq("fp.tie.m0_ready", 32'(m0_ready[1]), 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (r0) set_req(1, 0, rnd_addr(), $urandom(), 4'h0);
            if (r1) set_req(1, 1, rnd_addr(), $urandom(), 4'h0);
            step(1, r0, r1);
        end
        clr_req(1, 0);
        clr_req(1, 1);
        step(1, r0, r1);

        // Byte-lane write from M1, merged read by M0
        do_reset(0);
        s_ready[0] = 1'b1;
        set_req(0, 1, 32'h0001_0020, 32'h1122_3344, 4'hF);
        step(0, r0, r1);
        step(0, r0, r1);
        set_req(0, 1, 32'h0001_0020, 32'h00AB_0000, 4'b0100);
        step(0, r0, r1);
        step(0, r0, r1);
        clr_req(0, 1);
        set_req(0, 0, 32'h0001_0020, 32'h0, 4'h0);
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("byte.m0_rdata", m0_rdata[0], 32'h11AB_3344);
        tick();
        clr_req(0, 0);
        step(0, r0, r1);

        // Timeout: stuck slave, M0 cut loose on the 16th grant cycle, then M1 served
        do_reset(0);
        s_ready[0] = 1'b0;
        set_req(0, 0, 32'h0001_0014, 32'h0, 4'h0);
        set_req(0, 1, 32'h0001_0018, 32'h0, 4'h0);
        step(0, r0, r1);
        for (int i = 1; i < TMO; i++) begin
            cyc(0, r0, r1);
            check_eq("tmo.early.m0_ready", 32'(m0_ready[0]), 32'd0);
            tick();
        end
        cyc(0, r0, r1);
        check_eq("tmo.m0_ready", 32'(m0_ready[0]), 32'd1);
        check_eq("tmo.m0_rdata", m0_rdata[0], 32'd0);
        check_eq("tmo.s_valid", 32'(s_valid[0]), 32'd0);
        tick();
        clr_req(0, 0);
        s_ready[0] = 1'b1;
        cyc(0, r0, r1);
        check_eq("tmo.err_pulse", 32'(timeout_err[0]), 32'd1);
        check_eq("tmo.m1_grant", 32'(grant[0]), 32'h2);
        check_eq("tmo.m1_ready", 32'(m1_ready[0]), 32'd1);
        tick();
        clr_req(0, 1);
        step(0, r0, r1);

        // Reset while M1 holds the grant
        s_ready[0] = 1'b0;
        set_req(0, 1, 32'h0001_0030, 32'hCAFE_F00D, 4'hF);
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("rstg.grant_before", 32'(grant[0]), 32'h2);
        tick();
        rst[0] = 1'b1;
        s_ready[0] = 1'b1;
        cyc(0, r0, r1);
        check_eq("rstg.m1_ready_in_rst", 32'(m1_ready[0]), 32'd0);
        tick();
        rst[0] = 1'b0;
        s_ready[0] = 1'b0;
        cyc(0, r0, r1);
        check_eq("rstg.grant_after", 32'(grant[0]), 32'h0);
        check_eq("rstg.s_valid_after", 32'(s_valid[0]), 32'd0);
        check_eq("rstg.m1_ready_after", 32'(m1_ready[0]), 32'd0);
        tick();
        s_ready[0] = 1'b1;
        cyc(0, r0, r1);
        check_eq("rstg.rereq.m1_ready", 32'(m1_ready[0]), 32'd1);
        tick();
        clr_req(0, 1);
        set_req(0, 0, 32'h0001_0030, 32'h0, 4'h0);
        step(0, r0, r1);
        cyc(0, r0, r1);
        check_eq("rstg.readback", m0_rdata[0], 32'hCAFE_F00D);
        tick();
        clr_req(0, 0);
        step(0, r0, r1);

        // Randomized traffic on both arbitration modes
        for (int k = 0; k < NI; k++) begin
            do_reset(k);
            run_random(k, 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
